// File: rtl/tc_rr_arbiter8_if.sv
// Bundle of the arbiter's request/grant signals.
// The requester side (master) drives en, req and release_hold; the arbiter
// (slave) drives the registered grant outputs plus read-only debug taps.
// Handshake: a grant is offered whenever grant_valid=1, and it stays valid
// until the arbiter drops it. The requester may end it early with
// release_hold=1, by clearing req[sel], or with en=0; the arbiter ends it
// on its own after HOLD_MAX cycles. A terminated grant is always followed
// by at least one cycle with grant_valid=0.
// `release` is a reserved word in SystemVerilog, so the holder-finished
// strobe is called release_hold.
interface tc_rr_arbiter8_if;
    logic       en;
    logic [7:0] req;
    logic       release_hold;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       grant_valid;
    logic       dbg_state;
    logic [2:0] dbg_ptr;
    logic [7:0] dbg_cnt;

    modport master (
        output en, req, release_hold,
        input  grant, sel, grant_valid, dbg_state, dbg_ptr, dbg_cnt
    );

    modport slave (
        input  en, req, release_hold,
        output grant, sel, grant_valid, dbg_state, dbg_ptr, dbg_cnt
    );
endinterface

// File: rtl/tc_rr_arbiter8.sv
// Eight-way round-robin arbiter with a bounded hold time per winner.
// IDLE picks the first requester at or after the rotating pointer. HOLD
// keeps that grant until it is released, dropped or times out, and then
// moves the pointer past the last winner. Every output is a flop.
module tc_rr_arbiter8 #(
    parameter int unsigned HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    tc_rr_arbiter8_if.slave  bus
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q, ptr_d;
    logic [2:0] sel_q, sel_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] grant_q, grant_d;
    logic       gv_q, gv_d;
    logic [2:0] win;
    logic       found;
    logic       term;

    // Rotating priority scan: first set req bit at ptr, ptr+1, ... (mod 8).
    always_comb begin
        win   = ptr_q;
        found = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (!found && bus.req[ptr_q + 3'(k)]) begin
                found = 1'b1;
                win   = ptr_q + 3'(k);
            end
        end
    end

    // Any one of the end-of-grant causes is enough; they all have the same effect.
    assign term = bus.release_hold | ~bus.req[sel_q] | ~bus.en |
                  (cnt_q == 8'(HOLD_MAX));

    // State register; reset parks the FSM in IDLE with no clock edge needed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (bus.en && found) state_d = S_HOLD;
            S_HOLD: if (term)            state_d = S_IDLE;
            default:                     state_d = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, pointer and hold counter.
    always_comb begin
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        gv_d    = gv_q;
        case (state_q)
            S_IDLE: begin
                if (bus.en && found) begin
                    grant_d = 8'b1 << win;
                    sel_d   = win;
                    gv_d    = 1'b1;
                    cnt_d   = 8'd1;
                end else begin
                    grant_d = 8'd0;
                    gv_d    = 1'b0;
                end
            end
            S_HOLD: begin
                if (term) begin
                    grant_d = 8'd0;
                    gv_d    = 1'b0;
                    ptr_d   = sel_q + 3'd1;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                grant_d = 8'd0;
                gv_d    = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears the grant at once, even mid-hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q   <= 3'd0;
            sel_q   <= 3'd0;
            cnt_q   <= 8'd0;
            grant_q <= 8'd0;
            gv_q    <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            gv_q    <= gv_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.sel         = sel_q;
    assign bus.grant_valid = gv_q;
    assign bus.dbg_state   = state_q;
    assign bus.dbg_ptr     = ptr_q;
    assign bus.dbg_cnt     = cnt_q;

endmodule

// File: doc/tc_rr_arbiter8.md
TC_RR_ARBITER8 -- requirements
Module: tc_rr_arbiter8

Interface
REQ-001 Parameter: HOLD_MAX, default 8, maximum consecutive grant cycles per winner; legal range 1..255.
REQ-002 Single clock, asynchronous active-high reset; ports named clk and rst.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: rst  input  1  asynchronous active-high reset.
REQ-005 Port: en  input  1  arbitration enable; 0 blocks new grants and terminates the current grant.
REQ-006 Port: req  input  8  request vector; bit i set = requester i wants the resource.
REQ-007 Port: release  input  1  holder finished; terminates the current grant.
REQ-008 Port: grant  output  8  one-hot grant; all-zero when no grant.
REQ-009 Port: sel  output  3  binary index of the current or last winner; feeds a 3-to-8 decoder select.
REQ-010 Port: grant_valid  output  1  high exactly when grant is non-zero.

Function
REQ-011 States SHALL be IDLE and HOLD only.
REQ-012 Internal state: 3-bit priority pointer ptr and 8-bit hold counter cnt.
REQ-013 IDLE with en=1 and req!=0: winner = first set req bit scanning ptr, ptr+1, ... mod 8.
REQ-014 Next edge: grant=one-hot(winner), sel=winner, grant_valid=1, cnt=1, state=HOLD; request-to-grant latency 1 cycle.
REQ-015 IDLE with en=0 or req=0: stay IDLE; grant=0, grant_valid=0, sel and ptr unchanged.
REQ-016 HOLD termination when any of release=1, req[sel]=0, en=0, cnt==HOLD_MAX is sampled at an edge.
REQ-017 On termination: next cycle grant=0, grant_valid=0, state=IDLE, ptr=(sel+1) mod 8, cnt=0; sel retained.
REQ-018 Otherwise in HOLD: grant and sel unchanged, cnt incremented; cnt never exceeds HOLD_MAX.
REQ-019 One grant holds at most HOLD_MAX consecutive cycles, then at least one grant=0 cycle before any new grant.
REQ-020 Pointer wrap: sel=7 terminating SHALL set ptr=0.
REQ-021 New or changed req bits other than req[sel] SHALL be ignored during HOLD; evaluated only in IDLE.
REQ-022 Simultaneous termination causes SHALL produce one termination; no precedence visible at outputs.
REQ-023 grant SHALL be zero or one-hot in every cycle, and one-hot(sel) whenever grant_valid=1.
REQ-024 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-025 rst=1 SHALL immediately, without a clock edge, force grant=0, grant_valid=0, sel=0, ptr=0, cnt=0, state=IDLE.
REQ-026 rst asserted during HOLD SHALL drop the grant asynchronously; no grant until the first edge after rst deasserts.
REQ-027 First edge after rst deassertion SHALL evaluate as IDLE with ptr=0.

Verification
REQ-028 Reset, en=1, req=8'h81, release pulse on 2nd grant cycle -> grant 8'h01 sel=0 for 2 cycles, one zero cycle, grant 8'h80 sel=7; release -> ptr returns to 0.
REQ-029 HOLD_MAX=8, req=8'h08 held, no release -> grant 8'h08 for exactly 8 cycles, 1 zero cycle, then 8'h08 again.
REQ-030 req=8'hFF held, release every grant cycle -> grants 8'h01,02,04,...,80,01 alternating with single zero cycles.
REQ-031 During HOLD of requester 2, en=0 -> grant 0 next cycle; stays 0 while en=0 even with req=8'hFF; en=1 -> grant 8'h08.
REQ-032 During HOLD, rst pulsed between edges -> grant/grant_valid/sel zero before next edge; after release, req=8'h10 -> grant 8'h10 one cycle later.
REQ-033 Every cycle, assertion: grant==0 or onehot; grant_valid==(grant!=0); grant_valid implies grant==1<<sel.
